// File: rtl/ring_dump_monitor_if.sv
// ring_dump_monitor_if
// Bundles the four ring dump ports and the drain side (valid/pop, head
// fields, statistics) of ring_dump_monitor.
//   master modport : ring + drain logic side (drives strobes, data and pop)
//   slave modport  : the monitor itself
// Handshake: a dump strobe is a one-cycle event with its data valid in the
// same cycle (there is no ready). On the drain side, out_valid is high while
// the FIFO holds anything; pop consumes the head in the cycle it is
// high together with out_valid, and pop with out_valid low is ignored.
// Optional: out_stamp exists only when DUMP_MON_TIMESTAMP_EN is defined.
interface ring_dump_monitor_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    logic                     dump_packet_node0;
    logic                     dump_packet_node1;
    logic                     dump_packet_node2;
    logic                     dump_packet_node3;
    logic [63:0]              dump_data_node0;
    logic [63:0]              dump_data_node1;
    logic [63:0]              dump_data_node2;
    logic [63:0]              dump_data_node3;
    logic                     pop;
    logic                     out_valid;
    logic [63:0]              out_data;
    logic [1:0]               out_node;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [CNT_W-1:0]         total_count;
    logic [CNT_W-1:0]         drop_count;
    logic                     overflow;
`ifdef DUMP_MON_TIMESTAMP_EN
    logic [31:0]              out_stamp;
`endif

    modport master (
        output dump_packet_node0, dump_packet_node1, dump_packet_node2, dump_packet_node3,
        output dump_data_node0, dump_data_node1, dump_data_node2, dump_data_node3,
        output pop,
        input  out_valid, out_data, out_node, fifo_count,
        input  total_count, drop_count, overflow
`ifdef DUMP_MON_TIMESTAMP_EN
        , input out_stamp
`endif
    );

    modport slave (
        input  dump_packet_node0, dump_packet_node1, dump_packet_node2, dump_packet_node3,
        input  dump_data_node0, dump_data_node1, dump_data_node2, dump_data_node3,
        input  pop,
        output out_valid, out_data, out_node, fifo_count,
        output total_count, drop_count, overflow
`ifdef DUMP_MON_TIMESTAMP_EN
        , output out_stamp
`endif
    );
endinterface

// File: rtl/ring_dump_monitor.sv
// ring_dump_monitor
// Collects packets ejected on the four ring dump ports. Each node has a
// one-entry hold register; a round-robin arbiter moves one held packet per
// cycle into a show-ahead FIFO tagged with its source node. Saturating
// total/drop counters and a sticky overflow flag are kept alongside.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : ring_dump_monitor_if.slave (dump strobes/data, pop,
//                out_valid/out_data/out_node, fifo_count, total_count,
//                drop_count, overflow, optional out_stamp)
// Build option: define DUMP_MON_TIMESTAMP_EN to add a free-running 32-bit
// cycle counter whose value at capture travels with each entry to out_stamp.
module ring_dump_monitor #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                reset,
    ring_dump_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [3:0]        strobe;
    logic [63:0]       din [4];
    logic [3:0]        hold_full;
    logic [63:0]       hold_data [4];
    logic [1:0]        rr;
    logic              gnt_valid;
    logic [1:0]        gnt_node;
    logic [1:0]        scan_node;
    logic [3:0]        load;
    logic [3:0]        drop;
    logic [2:0]        drop_num;
    logic              push;
    logic              do_pop;
    logic              can_push;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [CNT_W-1:0]  total_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W:0]    drop_sum;
    logic              ovf;
    logic [63:0]       mem_data [DEPTH];
    logic [1:0]        mem_node [DEPTH];
`ifdef DUMP_MON_TIMESTAMP_EN
    logic [31:0]       cyc;
    logic [31:0]       hold_stamp [4];
    logic [31:0]       mem_stamp [DEPTH];
`endif

    assign strobe = {bus.dump_packet_node3, bus.dump_packet_node2,
                     bus.dump_packet_node1, bus.dump_packet_node0};
    assign din[0] = bus.dump_data_node0;
    assign din[1] = bus.dump_data_node1;
    assign din[2] = bus.dump_data_node2;
    assign din[3] = bus.dump_data_node3;

    // A slot is available if the FIFO is not full, or the head leaves this
    // same cycle (push+pop on a full FIFO keeps the occupancy at DEPTH).
    assign do_pop   = bus.pop && (count != '0);
    assign can_push = (count < FULL_LEVEL) || do_pop;

    // Round-robin: first full hold at or after rr, wrapping upward.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_node  = 2'd0;
        scan_node = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_node = rr + 2'(i);
            if (!gnt_valid && hold_full[scan_node]) begin
                gnt_valid = 1'b1;
                gnt_node  = scan_node;
            end
        end
        if (!can_push) begin
            gnt_valid = 1'b0;
        end
    end

    assign push = gnt_valid;

    // A granted hold frees its slot this cycle, so a same-cycle strobe on
    // that node reloads instead of dropping.
    always_comb begin
        load     = '0;
        drop     = '0;
        drop_num = 3'd0;
        for (int n = 0; n < 4; n++) begin
            load[n]  = strobe[n] && (!hold_full[n] || (push && gnt_node == 2'(n)));
            drop[n]  = strobe[n] && !load[n];
            drop_num = drop_num + {2'b00, drop[n]};
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_num);

    // Control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= '0;
            rr        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            total_cnt <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (load[n]) begin
                    hold_full[n] <= 1'b1;
                end else if (push && gnt_node == 2'(n)) begin
                    hold_full[n] <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr     <= gnt_node + 2'd1;
                if (total_cnt != '1) begin
                    total_cnt <= total_cnt + CNT_W'(1);
                end
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            if (drop != '0) begin
                ovf <= 1'b1;
            end
        end
    end

    // Data path: hold and FIFO storage need no reset, validity lives in the
    // flags and pointers above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < 4; n++) begin
                if (load[n]) begin
                    hold_data[n] <= din[n];
`ifdef DUMP_MON_TIMESTAMP_EN
                    hold_stamp[n] <= cyc;
`endif
                end
            end
            if (push) begin
                mem_data[wr_ptr] <= hold_data[gnt_node];
                mem_node[wr_ptr] <= gnt_node;
`ifdef DUMP_MON_TIMESTAMP_EN
                mem_stamp[wr_ptr] <= hold_stamp[gnt_node];
`endif
            end
        end
    end

`ifdef DUMP_MON_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + 32'd1;
        end
    end

    assign bus.out_stamp = mem_stamp[rd_ptr];
`endif

    assign bus.out_valid   = (count != '0);
    assign bus.out_data    = mem_data[rd_ptr];
    assign bus.out_node    = mem_node[rd_ptr];
    assign bus.fifo_count  = count;
    assign bus.total_count = total_cnt;
    assign bus.drop_count  = drop_cnt;
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_ring_dump_monitor.sv
// tb_ring_dump_monitor
// Self-checking bench for ring_dump_monitor: a table of per-cycle vectors,
// hand-written multi-cycle sequences, and randomized traffic compared with a
// queue-based reference model. Outputs are sampled 1 time unit after the
// rising edge; inputs are driven at the same point for the following edge.
module tb_ring_dump_monitor;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    ring_dump_monitor_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ring_dump_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  stb;
        logic [63:0] d;      // node n receives d + n
        logic        pop;
        logic        ev;
        int          ecnt;
        int          etot;
        int          edrop;
        logic        eovf;
        logic [1:0]  enode;
        logic [63:0] edata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] stb, logic [63:0] d, logic pop,
                                logic ev, int ecnt, int etot, int edrop, logic eovf,
                                logic [1:0] enode, logic [63:0] edata);
        vec_t v;
        v.rst = rst; v.stb = stb; v.d = d; v.pop = pop;
        v.ev = ev; v.ecnt = ecnt; v.etot = etot; v.edrop = edrop; v.eovf = eovf;
        v.enode = enode; v.edata = edata;
        return v;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    // exp_q entry = {stamp[31:0], node[1:0], data[63:0]}
    logic [97:0] exp_q[$];
    bit          m_full [4];
    logic [63:0] m_hold [4];
    logic [31:0] m_stamp [4];
    int          m_rr;
    int          m_tot;
    int          m_drop;
    bit          m_ovf;
    logic [31:0] m_cyc;

    logic [1:0]  con_node [5];
    logic [63:0] con_data [5];

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_full[n] = 0;
        exp_q.delete();
        m_rr = 0; m_tot = 0; m_drop = 0; m_ovf = 0; m_cyc = '0;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] stb,
                              input logic [255:0] d, input logic p);
        int g;
        int nd;
        bit can;
        if (rst) begin
            model_reset();
            return;
        end
        g = -1;
        can = (exp_q.size() < DEPTH) || (p && exp_q.size() > 0);
        if (can) begin
            for (int k = 0; k < 4; k++) begin
                int n = (m_rr + k) % 4;
                if (g < 0 && m_full[n]) g = n;
            end
        end
        if (p && exp_q.size() > 0) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back({m_stamp[g], 2'(g), m_hold[g]});
            m_rr = (g + 1) % 4;
            if (m_tot < MAXC) m_tot++;
        end
        nd = 0;
        for (int n = 0; n < 4; n++) begin
            if (stb[n]) begin
                if (!m_full[n] || n == g) begin
                    m_full[n]  = 1;
                    m_hold[n]  = d[n*64 +: 64];
                    m_stamp[n] = m_cyc;
                end else begin
                    nd++;
                end
            end else if (n == g) begin
                m_full[n] = 0;
            end
        end
        m_drop = (m_drop + nd > MAXC) ? MAXC : m_drop + nd;
        if (nd > 0) m_ovf = 1;
        m_cyc = m_cyc + 32'd1;
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [255:0] per_node(input logic [63:0] b);
        return {b + 64'd3, b + 64'd2, b + 64'd1, b};
    endfunction

    task automatic drive(input logic rst, input logic [3:0] stb,
                         input logic [255:0] d, input logic p);
        reset                 = rst;
        bus.dump_packet_node0 = stb[0];
        bus.dump_packet_node1 = stb[1];
        bus.dump_packet_node2 = stb[2];
        bus.dump_packet_node3 = stb[3];
        bus.dump_data_node0   = d[63:0];
        bus.dump_data_node1   = d[127:64];
        bus.dump_data_node2   = d[191:128];
        bus.dump_data_node3   = d[255:192];
        bus.pop               = p;
    endtask

    // Apply inputs for the current cycle and advance to the next one.
    task automatic cyc(input logic rst, input logic [3:0] stb,
                       input logic [255:0] d, input logic p);
        drive(rst, stb, d, p);
        @(posedge clk);
        #1;
        drive(1'b0, 4'h0, '0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 4'h0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 4'h0, '0, 1'b0);
        model_reset();
    endtask

    // ---------------- checkers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string t, input logic v, input int cnt, input int tot,
                               input int drp, input logic ovf);
        check({t, ".out_valid"},   64'(bus.out_valid),   64'(v));
        check({t, ".fifo_count"},  64'(bus.fifo_count),  64'(cnt));
        check({t, ".total_count"}, 64'(bus.total_count), 64'(tot));
        check({t, ".drop_count"},  64'(bus.drop_count),  64'(drp));
        check({t, ".overflow"},    64'(bus.overflow),    64'(ovf));
    endtask

    task automatic check_head(input string t, input logic [1:0] node, input logic [63:0] data);
        check({t, ".out_node"}, 64'(bus.out_node), 64'(node));
        check({t, ".out_data"}, bus.out_data, data);
    endtask

    task automatic compare_model(input int c);
        string t;
        t = $sformatf("rand[%0d]", c);
        check_state(t, exp_q.size() != 0, exp_q.size(), m_tot, m_drop, m_ovf);
        if (exp_q.size() != 0) begin
            check_head(t, exp_q[0][65:64], exp_q[0][63:0]);
`ifdef DUMP_MON_TIMESTAMP_EN
            check({t, ".out_stamp"}, 64'(bus.out_stamp), 64'(exp_q[0][97:66]));
`endif
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0]   r_stb;
        logic [255:0] r_d;
        logic         r_pop;
        logic         r_rst;
        int           phase;

        con_node = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        con_data = '{64'h01, 64'h03, 64'h11, 64'h23, 64'h31};

        do_reset();

        // Single event at cycle 5, then reset with strobes, then a 4-node burst.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 64'h0000_0001_DEAD_BEEF - 64'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 1, 1, 0, 0, 2, 64'h0000_0001_DEAD_BEEF));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 2, 64'h0000_0001_DEAD_BEEF));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 64'hFF00, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 1, 1, 0, 0, 0, 64'd0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 2, 2, 0, 0, 0, 64'd0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 3, 3, 0, 0, 0, 64'd0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 4, 4, 0, 0, 0, 64'd0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 3, 4, 0, 0, 1, 64'd1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 2, 4, 0, 0, 2, 64'd2));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 1, 4, 0, 0, 3, 64'd3));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 4, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec[%0d]", i);
            check_state(t, tbl[i].ev, tbl[i].ecnt, tbl[i].etot, tbl[i].edrop, tbl[i].eovf);
            if (tbl[i].ev) check_head(t, tbl[i].enode, tbl[i].edata);
            cyc(tbl[i].rst, tbl[i].stb, per_node(tbl[i].d), tbl[i].pop);
        end

        // Contention: nodes 1 and 3 strobe for 4 cycles; data = 16*cycle + node.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) check_state("contend_c2", 1, 1, 1, 1, 1);
            cyc(0, 4'b1010, per_node(64'(c * 16)), 0);
        end
        cyc(0, 4'h0, '0, 0);
        cyc(0, 4'h0, '0, 0);
        check_state("contend_end", 1, 5, 5, 3, 1);
        check("contend_sum", 64'(bus.total_count) + 64'(bus.drop_count), 64'd8);
        for (int i = 0; i < 5; i++) begin
            check_head($sformatf("contend_pop[%0d]", i), con_node[i], con_data[i]);
            cyc(0, 4'h0, '0, 1);
        end
        check_state("contend_drained", 0, 0, 5, 3, 1);

        // Pop on empty FIFO changes nothing.
        cyc(0, 4'h0, '0, 1);
        check_state("empty_pop", 0, 0, 5, 3, 1);

        // Reset with 5 entries queued and strobes in the reset cycle.
        for (int i = 0; i < 5; i++) cyc(0, 4'b0100, per_node(64'(32'h500 + i)), 0);
        cyc(0, 4'h0, '0, 0);
        check_state("pre_reset", 1, 5, 10, 3, 1);
        cyc(1, 4'hF, per_node(64'hBAD), 0);
        check_state("post_reset", 0, 0, 0, 0, 0);
        cyc(0, 4'h0, '0, 0);
        cyc(0, 4'h0, '0, 0);
        check_state("post_reset_settle", 0, 0, 0, 0, 0);

        // Full FIFO: 16 node1 entries, node0 waits in its hold, then drops.
        do_reset();
        for (int c = 0; c < 16; c++) cyc(0, 4'b0010, per_node(64'(32'h100 + c) - 64'd1), 0);
        cyc(0, 4'h0, '0, 0);
        check_state("full_fill", 1, 16, 16, 0, 0);
        cyc(0, 4'b0001, per_node(64'hA0), 0);
        check_state("full_hold", 1, 16, 16, 0, 0);
        cyc(0, 4'b0001, per_node(64'hA1), 0);
        check_state("full_drop", 1, 16, 16, 1, 1);
        cyc(0, 4'h0, '0, 1);
        check_state("full_pushpop", 1, 16, 17, 1, 1);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) check_head($sformatf("full_drain[%0d]", i), 2'd1, 64'(32'h101 + i));
            else        check_head("full_drain_last", 2'd0, 64'hA0);
            cyc(0, 4'h0, '0, 1);
        end
        check_state("full_empty", 0, 0, 17, 1, 1);

`ifdef DUMP_MON_TIMESTAMP_EN
        // Stamps: node0 strobes at cycles 10 and 13 after reset.
        do_reset();
        for (int c = 0; c < 15; c++) cyc(0, (c == 10 || c == 13) ? 4'b0001 : 4'h0, per_node(64'(c)), 0);
        check("stamp_first", 64'(bus.out_stamp), 64'd10);
        cyc(0, 4'h0, '0, 1);
        check("stamp_second", 64'(bus.out_stamp), 64'd13);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            compare_model(c);
            phase = (c / 300) % 3;
            r_stb = 4'h0;
            for (int n = 0; n < 4; n++) r_stb[n] = ($urandom_range(0, 99) < 35);
            case (phase)
                0:       r_pop = ($urandom_range(0, 99) < 10);
                1:       r_pop = ($urandom_range(0, 99) < 50);
                default: r_pop = ($urandom_range(0, 99) < 90);
            endcase
            r_rst = ($urandom_range(0, 499) == 0);
            r_d = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            model_step(r_rst, r_stb, r_d, r_pop);
            cyc(r_rst, r_stb, r_d, r_pop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
